// File: rtl/osd_wb_pkg.sv
// Shared Wishbone B3 constants and the responder state type for the OSD
// SRAM slave.
package osd_wb_pkg;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST
    } wb_state_t;

endpackage

// File: rtl/osd_wb_sram_slave_mem.sv
// Single-port-per-direction synchronous SRAM: one-cycle read latency and
// per-byte write enables.
module osd_wb_sram_slave_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset branch so it maps onto a plain RAM macro;
    // only the read-data register is cleared.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/osd_wb_sram_slave.sv
// Wishbone B3 SRAM responder: classic cycles plus linear incrementing bursts
// with a read prefetch that sustains one acknowledge per cycle.
module osd_wb_sram_slave
    import osd_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam logic [MEM_ADDR_WIDTH:0] CNT_ONE = {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};

    wb_state_t                 state, state_next;
    logic [MEM_ADDR_WIDTH:0]   cnt, cnt_next, cnt_init, cnt_inc;
    logic [ADDR_WIDTH-1:0]     widx;
    logic                      widx_oor;
    logic                      beat, ack_en, err_en, wr_beat, rd_en;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr;
    logic [BYTES-1:0]          wr_be;

    assign widx     = addr_i >> OFF;
    assign widx_oor = |(widx >> MEM_ADDR_WIDTH);
    // Far-out addresses saturate to the first out-of-range index so that
    // truncation can never alias them back into the memory.
    assign cnt_init = widx_oor ? {1'b1, {MEM_ADDR_WIDTH{1'b0}}}
                               : {1'b0, widx[MEM_ADDR_WIDTH-1:0]};
    assign cnt_inc  = cnt + CNT_ONE;
    assign beat     = cyc_i & stb_i;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ack_en     = 1'b0;
        err_en     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = cnt[MEM_ADDR_WIDTH-1:0];
        case (state)
            ST_IDLE: begin
                rd_addr = widx[MEM_ADDR_WIDTH-1:0];
                if (beat) begin
                    cnt_next   = cnt_init;
                    rd_en      = ~we_i;
                    state_next = (cti_i == WB_CTI_INCR && bte_i == WB_BTE_LINEAR)
                                 ? ST_BURST : ST_CLASSIC;
                end
            end
            ST_CLASSIC: begin
                ack_en     = ~cnt[MEM_ADDR_WIDTH];
                err_en     = cnt[MEM_ADDR_WIDTH];
                state_next = ST_IDLE;
            end
            ST_BURST: begin
                ack_en = ~cnt[MEM_ADDR_WIDTH];
                err_en = cnt[MEM_ADDR_WIDTH];
                rd_en  = 1'b1;
                if (!cyc_i) begin
                    state_next = ST_IDLE;
                end else if (stb_i) begin
                    if (err_en) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_inc;
                        rd_addr  = cnt_inc[MEM_ADDR_WIDTH-1:0];
                        if (cti_i == WB_CTI_EOB) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ack_o = ack_en & beat;
    assign err_o = err_en & beat;

    // A beat still acknowledged while reset is asserted is dropped.
    assign wr_beat = ack_o & we_i & ~rst_i;
    assign wr_be   = {BYTES{wr_beat}} & sel_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    osd_wb_sram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_be   (wr_be),
        .wr_addr (cnt[MEM_ADDR_WIDTH-1:0]),
        .wr_data (dat_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (dat_o)
    );

endmodule

// File: tb/tb_osd_wb_sram_slave.sv
// Self-checking bench for osd_wb_sram_slave: directed scenarios followed by
// random classic/burst traffic checked against an array model of the memory.
module tb_osd_wb_sram_slave;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int MAW   = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_i, cyc_i, stb_i, we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] dat_i;
    logic [1:0]    sel_i;
    logic [2:0]    cti_i;
    logic [1:0]    bte_i;
    logic          ack_o, err_o;
    logic [DW-1:0] dat_o;

    logic [DW-1:0] model [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    osd_wb_sram_slave #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MEM_ADDR_WIDTH (MAW)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .dat_i  (dat_i),
        .sel_i  (sel_i),
        .cti_i  (cti_i),
        .bte_i  (bte_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .dat_o  (dat_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 2; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Waits (bounded) for ack/err on the currently driven beat, checks it,
    // then lets the clock edge that commits the beat pass.
    task automatic beat(input string tag, input bit exp_err, input int exp_lat,
                        input bit chk_data, input logic [DW-1:0] exp_data);
        logic          a, e;
        logic [DW-1:0] d;
        int            lat;
        a = 1'b0; e = 1'b0; d = '0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_o || err_o) begin
                a = ack_o; e = err_o; d = dat_o;
                break;
            end
            lat++;
        end
        check($sformatf("%s resp", tag), {31'd0, a | e}, 32'd1);
        check($sformatf("%s ack/err", tag), {30'd0, a, e}, exp_err ? 32'd1 : 32'd2);
        check($sformatf("%s latency", tag), lat, exp_lat);
        if (chk_data && a) check($sformatf("%s data", tag), {16'd0, d}, {16'd0, exp_data});
        @(posedge clk); #1;
    endtask

    task automatic classic(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] data,
                           input logic [1:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        logic [31:0] idx;
        bit          oor;
        idx = addr >> 1;
        oor = (idx >= DEPTH);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = wr; addr_i = addr;
        dat_i = data; sel_i = sel; cti_i = cti; bte_i = bte;
        beat($sformatf("classic %s @%0h", wr ? "wr" : "rd", addr), oor, 1, !wr,
             oor ? '0 : model[idx[MAW-1:0]]);
        if (wr && !oor) model[idx[MAW-1:0]] = merge(model[idx[MAW-1:0]], data, sel);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic burst(input logic [AW-1:0] addr, input int n, input bit wr,
                         input logic [DW-1:0] data [8], input logic [1:0] sel, input int pause);
        logic [31:0] idx;
        bit          oor;
        cyc_i = 1'b1; we_i = wr; bte_i = 2'b00; sel_i = sel;
        for (int i = 0; i < n; i++) begin
            idx    = (addr >> 1) + i;
            oor    = (idx >= DEPTH);
            stb_i  = 1'b1;
            addr_i = addr + 32'(2 * i);
            dat_i  = data[i];
            cti_i  = (i == n - 1) ? 3'b111 : 3'b010;
            beat($sformatf("burst %s @%0h beat %0d", wr ? "wr" : "rd", addr, i), oor,
                 (i == 0) ? 1 : 0, !wr, oor ? '0 : model[idx[MAW-1:0]]);
            if (oor) break;
            if (wr) model[idx[MAW-1:0]] = merge(model[idx[MAW-1:0]], data[i], sel);
            if (i < n - 1 && pause > 0) begin
                stb_i = 1'b0;
                for (int p = 0; p < pause; p++) begin
                    @(negedge clk);
                    check("wait state no resp", {30'd0, ack_o, err_o}, 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
        // Bus still requesting right after the last beat: an idle responder
        // must not acknowledge.
        stb_i = 1'b1; cti_i = 3'b000;
        @(negedge clk);
        check("idle after burst", {30'd0, ack_o, err_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] wd [8];
        logic [31:0]   ridx, raddr;
        int            kind, n;

        rst_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = '0;
        dat_i = '0; sel_i = 2'b11; cti_i = 3'b000; bte_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset ack/err", {30'd0, ack_o, err_o}, 32'd0);
        check("reset dat_o", {16'd0, dat_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Fill the whole memory so every later read has a known value.
        for (int blk = 0; blk < DEPTH / 8; blk++) begin
            for (int k = 0; k < 8; k++) wd[k] = 16'($urandom());
            burst(32'(blk * 16), 8, 1'b1, wd, 2'b11, 0);
        end

        classic(32'h10, 1'b1, 16'hBEEF, 2'b11, 3'b000, 2'b00);
        classic(32'h10, 1'b0, '0, 2'b11, 3'b000, 2'b00);
        check("beef stored", {16'd0, model[8]}, 32'h0000BEEF);
        classic(32'h10, 1'b1, 16'h12AB, 2'b01, 3'b000, 2'b00);
        classic(32'h10, 1'b0, '0, 2'b11, 3'b000, 2'b00);
        check("byte lane merge", {16'd0, model[8]}, 32'h0000BEAB);

        for (int k = 0; k < 8; k++) wd[k] = 16'(k + 1);
        burst(32'h20, 4, 1'b1, wd, 2'b11, 0);
        burst(32'h20, 4, 1'b0, wd, 2'b11, 0);
        burst(32'h20, 4, 1'b0, wd, 2'b11, 2);

        classic(32'h200, 1'b0, '0, 2'b11, 3'b000, 2'b00);
        for (int k = 0; k < 8; k++) wd[k] = 16'hA500 + 16'(k);
        burst(32'h1FC, 3, 1'b1, wd, 2'b11, 0);
        classic(32'h0, 1'b0, '0, 2'b11, 3'b000, 2'b00);
        classic(32'h2, 1'b0, '0, 2'b11, 3'b000, 2'b00);

        // Reset while the third beat of a write burst is pending.
        cyc_i = 1'b1; we_i = 1'b1; bte_i = 2'b00; sel_i = 2'b11; stb_i = 1'b1;
        cti_i = 3'b010;
        addr_i = 32'h40; dat_i = 16'h1111;
        beat("rst burst beat 0", 1'b0, 1, 1'b0, '0);
        model[32] = 16'h1111;
        addr_i = 32'h42; dat_i = 16'h2222;
        beat("rst burst beat 1", 1'b0, 0, 1'b0, '0);
        model[33] = 16'h2222;
        addr_i = 32'h44; dat_i = 16'h3333; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("after mid-burst reset ack/err", {30'd0, ack_o, err_o}, 32'd0);
        check("after mid-burst reset dat_o", {16'd0, dat_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) classic(32'h40 + 32'(2 * k), 1'b0, '0, 2'b11, 3'b000, 2'b00);

        for (int t = 0; t < 80; t++) begin
            kind = int'($urandom_range(0, 2));
            ridx = ($urandom_range(0, 9) == 0) ? 32'd250 + $urandom_range(0, 12)
                                               : $urandom_range(0, DEPTH - 1);
            raddr = (ridx << 1) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) raddr = raddr | 32'h0001_0000;
            for (int k = 0; k < 8; k++) wd[k] = 16'($urandom());
            if (kind == 0) begin
                classic(raddr, 1'($urandom_range(0, 1)), wd[0], 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000, 2'($urandom_range(0, 3)));
            end else if (kind == 1) begin
                classic(raddr, 1'($urandom_range(0, 1)), wd[0], 2'($urandom_range(0, 3)),
                        3'b010, 2'($urandom_range(1, 3)));
            end else begin
                n = int'($urandom_range(1, 8));
                burst(raddr, n, 1'($urandom_range(0, 1)), wd, 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
